// File: rtl/pll_lock_supervisor.sv
// Per-channel PLL lock supervisor: synchronises raw LOCK, sequences PLL reset/lock
// attempts with retry and sticky fault, and qualifies a filtered clock-good per channel.
module pll_lock_supervisor #(
  parameter int N_PLL      = 2,
  parameter int RESET_HOLD = 4,
  parameter int TIMEOUT    = 16,
  parameter int LOCK_FILT  = 8,
  parameter int MAX_RETRY  = 2
) (
  input  logic             REFERENCECLK,
  input  logic             RESET,
  input  logic [N_PLL-1:0] PLL_LOCK,
  input  logic             BYPASS,
  input  logic [N_PLL-1:0] CLR_FAULT,
  output logic [N_PLL-1:0] PLL_RESETB,
  output logic [N_PLL-1:0] PLL_BYPASS,
  output logic [N_PLL-1:0] CLK_GOOD,
  output logic [N_PLL-1:0] FAULT,
  output logic [N_PLL-1:0] LOSS_PULSE,
  output logic             ALL_GOOD
);

  localparam int CMAX_A = (RESET_HOLD > TIMEOUT) ? RESET_HOLD : TIMEOUT;
  localparam int CMAX   = (CMAX_A > LOCK_FILT) ? CMAX_A : LOCK_FILT;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_HOLD, ST_WAIT, ST_FILTER, ST_LOCKED, ST_FAULT
  } state_t;

  logic [N_PLL-1:0] sync_p0;
  logic [N_PLL-1:0] lock_s;
  logic             byp_q;
  logic             force_hold;

  // stage 0/1: two-flop lock synchroniser and registered bypass
  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= '0;
      lock_s  <= '0;
      byp_q   <= 1'b0;
    end else begin
      sync_p0 <= PLL_LOCK;
      lock_s  <= sync_p0;
      byp_q   <= BYPASS;
    end
  end

  // Holding for the cycle after bypass falls makes the post-bypass HOLD a full RESET_HOLD long.
  assign force_hold = BYPASS | byp_q;

  for (genvar i = 0; i < N_PLL; i++) begin : g_ch
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retry, retry_n;
    logic          loss, loss_n;
    logic          resetb, good, fault;

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
      if (RESET) begin
        state <= ST_HOLD;
        cnt   <= '0;
        retry <= '0;
        loss  <= 1'b0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        retry <= retry_n;
        loss  <= loss_n;
      end
    end

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      retry_n = retry;
      loss_n  = 1'b0;
      if (force_hold) begin
        state_n = ST_HOLD;
        cnt_n   = '0;
        retry_n = '0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state_n = ST_WAIT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          ST_WAIT: begin
            if (lock_s[i]) begin
              state_n = ST_FILTER;
              cnt_n   = '0;
            end else if (cnt == WAIT_LAST) begin
              cnt_n = '0;
              if (retry == RETRY_MAX) begin
                state_n = ST_FAULT;
              end else begin
                state_n = ST_HOLD;
                retry_n = retry + RW'(1);
              end
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          ST_FILTER: begin
            if (!lock_s[i]) begin
              state_n = ST_WAIT;
              cnt_n   = '0;
            end else if (cnt == FILT_LAST) begin
              state_n = ST_LOCKED;
              cnt_n   = '0;
              retry_n = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          ST_LOCKED: begin
            if (!lock_s[i]) begin
              state_n = ST_HOLD;
              cnt_n   = '0;
              retry_n = '0;
              loss_n  = 1'b1;
            end
          end
          ST_FAULT: begin
            if (CLR_FAULT[i]) begin
              state_n = ST_HOLD;
              cnt_n   = '0;
              retry_n = '0;
            end
          end
          default: begin
            state_n = ST_HOLD;
            cnt_n   = '0;
            retry_n = '0;
          end
        endcase
      end
    end

    always_comb begin
      resetb = !((state == ST_HOLD) || (state == ST_FAULT));
      good   = (state == ST_LOCKED) || byp_q;
      fault  = (state == ST_FAULT) && !byp_q;
    end

    assign PLL_RESETB[i] = resetb;
    assign PLL_BYPASS[i] = byp_q;
    assign CLK_GOOD[i]   = good;
    assign FAULT[i]      = fault;
    assign LOSS_PULSE[i] = loss;
  end

  assign ALL_GOOD = &CLK_GOOD;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: timed expectations are queued as stimulus
// is applied and compared when the monitor reaches their cycle.
module tb_pll_lock_supervisor;
  localparam int SEL_RSTB = 0, SEL_BYP = 1, SEL_GOOD = 2, SEL_FAULT = 3, SEL_LOSS = 4, SEL_ALLG = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lock, clr;
  logic       byp;
  logic [1:0] resetb, pbyp, good, fault, loss;
  logic       allg;

  typedef struct {
    int         cyc;
    string      tag;
    int         sel;
    logic [1:0] mask;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .N_PLL(2), .RESET_HOLD(4), .TIMEOUT(16), .LOCK_FILT(8), .MAX_RETRY(2)
  ) dut (
    .REFERENCECLK(clk),
    .RESET       (rst),
    .PLL_LOCK    (lock),
    .BYPASS      (byp),
    .CLR_FAULT   (clr),
    .PLL_RESETB  (resetb),
    .PLL_BYPASS  (pbyp),
    .CLK_GOOD    (good),
    .FAULT       (fault),
    .LOSS_PULSE  (loss),
    .ALL_GOOD    (allg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [1:0] pick(input int sel);
    case (sel)
      SEL_RSTB:  return resetb;
      SEL_BYP:   return pbyp;
      SEL_GOOD:  return good;
      SEL_FAULT: return fault;
      SEL_LOSS:  return loss;
      default:   return {1'b0, allg};
    endcase
  endfunction

  task automatic expect_at(input int k, input string tag, input int sel,
                           input logic [1:0] mask, input logic [1:0] val);
    exp_t e;
    int   idx;
    e.cyc = cyc + k; e.tag = tag; e.sel = sel; e.mask = mask; e.val = val;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
    sb.insert(idx, e);
  endtask

  // Three lock attempts (4 low + 16 high each) then a sticky fault at offset base+60.
  task automatic push_attempts(input int base, input logic [1:0] mask, input string tag);
    for (int j = 0; j < 64; j++) begin
      if (base + j >= 1)
        expect_at(base + j, tag, SEL_RSTB, mask, (((j % 20) < 4) || (j >= 60)) ? 2'b00 : mask);
    end
    expect_at(base + 59, {tag, "_fault_pre"}, SEL_FAULT, mask, 2'b00);
    expect_at(base + 60, {tag, "_fault"}, SEL_FAULT, mask, mask);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstb"}, resetb, 2'b00);
    chk({tag, "_pbyp"}, pbyp, 2'b00);
    chk({tag, "_good"}, good, 2'b00);
    chk({tag, "_fault"}, fault, 2'b00);
    chk({tag, "_loss"}, loss, 2'b00);
    chk({tag, "_allg"}, allg, 1'b0);
  endtask

  // Monitor: one cycle index per rising edge, compare everything due at that index.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk(e.tag, pick(e.sel) & e.mask, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lock = 2'b00; clr = 2'b00; byp = 1'b0;
    tick(3);
    chk_reset_vals("por");

    // three failed attempts on both channels end in FAULT
    rst = 1'b0;
    push_attempts(0, 2'b11, "attempts");
    tick(66);

    // clear channel 0 only: fresh three attempts, channel 1 stays faulted
    clr = 2'b01;
    push_attempts(1, 2'b01, "clr0_attempts");
    expect_at(1, "ch1_still_fault", SEL_FAULT, 2'b10, 2'b10);
    tick(1); clr = 2'b00;
    tick(64);

    // clear both, lock ch0 five cycles into WAIT
    clr = 2'b11;
    expect_at(1, "fault_cleared", SEL_FAULT, 2'b11, 2'b00);
    tick(1); clr = 2'b00;
    tick(8);
    lock[0] = 1'b1;
    expect_at(10, "good0_pre", SEL_GOOD, 2'b01, 2'b00);
    expect_at(11, "good0_rise", SEL_GOOD, 2'b01, 2'b01);
    expect_at(11, "allg_one_ch", SEL_ALLG, 2'b01, 2'b00);
    tick(17);

    // ch1 locks on its second attempt with a one-cycle glitch in FILTER
    lock[1] = 1'b1;
    expect_at(8, "glitch_wait_rstb", SEL_RSTB, 2'b10, 2'b10);
    expect_at(11, "glitch_no_early", SEL_GOOD, 2'b10, 2'b00);
    expect_at(16, "glitch_good_pre", SEL_GOOD, 2'b10, 2'b00);
    expect_at(17, "glitch_good", SEL_GOOD, 2'b10, 2'b10);
    expect_at(16, "allg_pre", SEL_ALLG, 2'b01, 2'b00);
    expect_at(17, "allg_rise", SEL_ALLG, 2'b01, 2'b01);
    tick(5); lock[1] = 1'b0;
    tick(1); lock[1] = 1'b1;
    tick(12);

    // CLR_FAULT while LOCKED does nothing
    clr = 2'b11;
    expect_at(1, "clr_lk_good1", SEL_GOOD, 2'b11, 2'b11);
    expect_at(2, "clr_lk_good2", SEL_GOOD, 2'b11, 2'b11);
    expect_at(2, "clr_lk_fault", SEL_FAULT, 2'b11, 2'b00);
    expect_at(2, "clr_lk_rstb", SEL_RSTB, 2'b11, 2'b11);
    tick(1); clr = 2'b00;
    tick(2);

    // ch1 loses lock: one loss pulse, 4-cycle HOLD, requalify
    lock[1] = 1'b0;
    expect_at(2, "loss_pre", SEL_LOSS, 2'b11, 2'b00);
    expect_at(2, "good1_hold", SEL_GOOD, 2'b10, 2'b10);
    expect_at(3, "loss_pulse", SEL_LOSS, 2'b11, 2'b10);
    expect_at(3, "good1_drop", SEL_GOOD, 2'b10, 2'b00);
    expect_at(3, "good0_kept", SEL_GOOD, 2'b01, 2'b01);
    expect_at(4, "loss_end", SEL_LOSS, 2'b11, 2'b00);
    for (int k = 3; k <= 6; k++) expect_at(k, "relock_hold", SEL_RSTB, 2'b10, 2'b00);
    expect_at(7, "relock_wait", SEL_RSTB, 2'b10, 2'b10);
    expect_at(15, "requal_pre", SEL_GOOD, 2'b10, 2'b00);
    expect_at(16, "requal", SEL_GOOD, 2'b10, 2'b10);
    tick(2); lock[1] = 1'b1;
    tick(16);

    // ch0 back to WAIT, then bypass arrives as ch1 loses lock
    lock[0] = 1'b0;
    expect_at(3, "loss0_pulse", SEL_LOSS, 2'b01, 2'b01);
    tick(7);
    lock[1] = 1'b0;
    expect_at(2, "byp_pre_good", SEL_GOOD, 2'b11, 2'b10);
    expect_at(2, "byp_pre_pbyp", SEL_BYP, 2'b11, 2'b00);
    expect_at(2, "byp_pre_wait", SEL_RSTB, 2'b01, 2'b01);
    tick(2);
    byp = 1'b1;
    expect_at(1, "byp_pbyp", SEL_BYP, 2'b11, 2'b11);
    expect_at(1, "byp_good", SEL_GOOD, 2'b11, 2'b11);
    expect_at(1, "byp_fault", SEL_FAULT, 2'b11, 2'b00);
    expect_at(1, "byp_allg", SEL_ALLG, 2'b01, 2'b01);
    for (int k = 1; k <= 3; k++) expect_at(k, "byp_no_loss", SEL_LOSS, 2'b11, 2'b00);
    expect_at(4, "byp_held_good", SEL_GOOD, 2'b11, 2'b11);
    expect_at(4, "byp_held_pbyp", SEL_BYP, 2'b11, 2'b11);
    tick(4);
    byp = 1'b0;
    expect_at(1, "unbyp_good", SEL_GOOD, 2'b11, 2'b00);
    expect_at(1, "unbyp_pbyp", SEL_BYP, 2'b11, 2'b00);
    expect_at(1, "unbyp_allg", SEL_ALLG, 2'b01, 2'b00);
    for (int k = 1; k <= 4; k++) expect_at(k, "unbyp_hold", SEL_RSTB, 2'b11, 2'b00);
    expect_at(5, "unbyp_wait", SEL_RSTB, 2'b11, 2'b11);
    tick(6);

    // both channels into FILTER, then asynchronous reset mid-FILTER
    lock = 2'b11;
    tick(5);
    chk("filt_rstb", resetb, 2'b11);
    chk("filt_good", good, 2'b00);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    tick(2);
    chk("rst_held_rstb", resetb, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) expect_at(k, "post_rst_hold", SEL_RSTB, 2'b11, 2'b00);
    expect_at(4, "post_rst_wait", SEL_RSTB, 2'b11, 2'b11);
    expect_at(12, "post_rst_good_pre", SEL_GOOD, 2'b11, 2'b00);
    expect_at(13, "post_rst_good", SEL_GOOD, 2'b11, 2'b11);
    expect_at(13, "post_rst_allg", SEL_ALLG, 2'b01, 2'b01);
    tick(15);

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick(1);
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
